// File: rtl/mux_gate_scheduler_if.sv
// Request/response bundle for mux_gate_scheduler: per-requester opcode and operands in,
// one-hot grant, busy, done pulse, done_id and result out. dbg_state mirrors the FSM state.
interface mux_gate_scheduler_if #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 8
);
    localparam int IDW = $clog2(N_REQ);

    // Handshake: a requester holds req high until it sees its grant bit; the unit samples
    // req only while idle, and the result is valid exactly in the cycle done is high.
    logic [N_REQ-1:0]       req;
    logic [3*N_REQ-1:0]     op;
    logic [WIDTH*N_REQ-1:0] opa;
    logic [WIDTH*N_REQ-1:0] opb;
    logic [N_REQ-1:0]       grant;
    logic                   busy;
    logic                   done;
    logic [IDW-1:0]         done_id;
    logic [WIDTH-1:0]       result;
    logic [1:0]             dbg_state;

    modport master (
        output req, op, opa, opb,
        input  grant, busy, done, done_id, result, dbg_state
    );

    modport slave (
        input  req, op, opa, opb,
        output grant, busy, done, done_id, result, dbg_state
    );
endinterface

// File: rtl/mux_gate_scheduler.sv
// Round-robin scheduler for a bit-serial, single-2:1-mux gate unit (one result bit per clock).
// Define MUX_SCHED_FIXED_PRIO_EN for lowest-index-wins arbitration with no rotating pointer.
module mux_gate_scheduler #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 8
) (
    input logic clk,
    input logic rst,
    mux_gate_scheduler_if.slave bus
);
    localparam int IDW = $clog2(N_REQ);
    localparam int CW  = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EVAL = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    idx_q, idx_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [2:0]       opc_q, opc_d;
    logic [IDW-1:0]   id_q, id_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [IDW-1:0]   done_id_q, done_id_d;

    logic             found;
    logic [IDW-1:0]   win;
    logic             i0, i1, y;
    logic [WIDTH-1:0] sr_shift;

`ifdef MUX_SCHED_FIXED_PRIO_EN
    always_comb begin
        found = 1'b0;
        win   = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (bus.req[k]) begin
                found = 1'b1;
                win   = IDW'(k);
            end
        end
    end
`else
    logic [IDW-1:0] ptr_q, ptr_d;

    // Walk downward so the last hit is the first requester at or above the pointer.
    always_comb begin
        int j;
        found = 1'b0;
        win   = '0;
        j     = 0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            j = int'(ptr_q) + k;
            if (j >= N_REQ) j = j - N_REQ;
            if (bus.req[j]) begin
                found = 1'b1;
                win   = IDW'(j);
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (state_q == IDLE && found) begin
            ptr_d = (int'(win) == N_REQ - 1) ? '0 : win + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) ptr_q <= '0;
        else     ptr_q <= ptr_d;
    end
`endif

    // The A bit is the mux select; the opcode only chooses what feeds i0/i1.
    always_comb begin
        i0 = 1'b0;
        i1 = 1'b0;
        case (opc_q)
            3'd0:    begin i0 = 1'b0;     i1 = b_q[0];   end
            3'd1:    begin i0 = b_q[0];   i1 = 1'b1;     end
            3'd2:    begin i0 = 1'b1;     i1 = ~b_q[0];  end
            3'd3:    begin i0 = ~b_q[0];  i1 = 1'b0;     end
            3'd4:    begin i0 = b_q[0];   i1 = ~b_q[0];  end
            3'd5:    begin i0 = ~b_q[0];  i1 = b_q[0];   end
            default: begin i0 = 1'b0;     i1 = 1'b0;     end
        endcase
        y = a_q[0] ? i1 : i0;
        sr_shift            = sr_q >> 1;
        sr_shift[WIDTH-1]   = y;
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        a_d       = a_q;
        b_d       = b_q;
        opc_d     = opc_q;
        id_d      = id_q;
        sr_d      = sr_q;
        result_d  = result_q;
        done_id_d = done_id_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    id_d    = win;
                    opc_d   = bus.op[3*int'(win) +: 3];
                    a_d     = bus.opa[WIDTH*int'(win) +: WIDTH];
                    b_d     = bus.opb[WIDTH*int'(win) +: WIDTH];
                    idx_d   = '0;
                    state_d = EVAL;
                end
            end
            EVAL: begin
                sr_d  = sr_shift;
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                idx_d = idx_q + 1'b1;
                if (idx_q == LAST_IDX) begin
                    result_d  = sr_shift;
                    done_id_d = id_q;
                    state_d   = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            a_q       <= '0;
            b_q       <= '0;
            opc_q     <= '0;
            id_q      <= '0;
            sr_q      <= '0;
            result_q  <= '0;
            done_id_q <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            a_q       <= a_d;
            b_q       <= b_d;
            opc_q     <= opc_d;
            id_q      <= id_d;
            sr_q      <= sr_d;
            result_q  <= result_d;
            done_id_q <= done_id_d;
        end
    end

    // Grant is the first EVAL cycle only, so it can never overlap done.
    assign bus.grant     = (state_q == EVAL && idx_q == '0)
                           ? ({{(N_REQ-1){1'b0}}, 1'b1} << id_q) : '0;
    assign bus.busy      = (state_q != IDLE);
    assign bus.done      = (state_q == DONE);
    assign bus.done_id   = done_id_q;
    assign bus.result    = result_q;
    assign bus.dbg_state = state_q;
endmodule
